// File: rtl/dest_drain_arbiter.sv
// Round-robin drain of two destination FIFOs into a single valid/ready sink.
// Define DRAIN_COUNT_EN to build the per-FIFO drained-word counters.
module dest_drain_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       empty_D0,
  input  logic       empty_D1,
  input  logic [5:0] data_out0,
  input  logic [5:0] data_out1,
  input  logic       ready_out,
  output logic       pop_D0,
  output logic       pop_D1,
  output logic [5:0] data_out,
  output logic       valid_out,
  output logic       dest_out,
  output logic [7:0] count_D0,
  output logic [7:0] count_D1,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    POP  = 2'b01,
    CAPT = 2'b10,
    HOLD = 2'b11
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic       sel_r;
  logic       last_r;
  logic       sel_new_s;
  logic       eligible_s;
  logic [5:0] data_r;
  logic       valid_r;
  logic       dest_r;

  assign data_out  = data_r;
  assign valid_out = valid_r;
  assign dest_out  = dest_r;

  // Eligibility for a new drain and the round-robin pick of the next source
  always_comb begin
    eligible_s = enable && (!empty_D0 || !empty_D1);
    if (!empty_D0 && !empty_D1) begin
      sel_new_s = ~last_r;
    end else if (!empty_D0) begin
      sel_new_s = 1'b0;
    end else begin
      sel_new_s = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; an accepted word may chain straight into the next pop
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (eligible_s) begin
          state_next_s = POP;
        end else begin
          state_next_s = IDLE;
        end
      end
      POP:  state_next_s = CAPT;
      CAPT: state_next_s = HOLD;
      HOLD: begin
        if (!ready_out) begin
          state_next_s = HOLD;
        end else if (eligible_s) begin
          state_next_s = POP;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from registered state and selection
  always_comb begin
    pop_D0 = (state_r == POP) && (sel_r == 1'b0);
    pop_D1 = (state_r == POP) && (sel_r == 1'b1);
    busy   = (state_r != IDLE);
  end

  // Arbitration registers; last starts at 1 so D0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_r  <= 1'b0;
      last_r <= 1'b1;
    end else begin
      if (state_next_s == POP) begin
        sel_r <= sel_new_s;
      end else begin
        sel_r <= sel_r;
      end
      if (state_r == CAPT) begin
        last_r <= sel_r;
      end else begin
        last_r <= last_r;
      end
    end
  end

  // Output word register: load on capture, hold until the sink accepts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r  <= 6'h00;
      valid_r <= 1'b0;
      dest_r  <= 1'b0;
    end else if (state_r == CAPT) begin
      data_r  <= sel_r ? data_out1 : data_out0;
      valid_r <= 1'b1;
      dest_r  <= sel_r;
    end else if ((state_r == HOLD) && ready_out) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

`ifdef DRAIN_COUNT_EN
  logic [7:0] count_d0_r;
  logic [7:0] count_d1_r;

  // Per-FIFO drained-word counters, wrapping silently at 8 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_d0_r <= 8'h00;
      count_d1_r <= 8'h00;
    end else if (state_r == CAPT) begin
      if (sel_r) begin
        count_d1_r <= count_d1_r + 8'd1;
      end else begin
        count_d0_r <= count_d0_r + 8'd1;
      end
    end else begin
      count_d0_r <= count_d0_r;
      count_d1_r <= count_d1_r;
    end
  end

  assign count_D0 = count_d0_r;
  assign count_D1 = count_d1_r;
`else
  assign count_D0 = 8'h00;
  assign count_D1 = 8'h00;
`endif

endmodule

// File: tb/tb_dest_drain_arbiter.sv
// Randomized bench for dest_drain_arbiter: FIFO models drive the DUT and a
// transaction-level round-robin model predicts every pop and delivered word.
module tb_dest_drain_arbiter;
  logic       clk = 1'b0;
  logic       reset, enable, empty_D0, empty_D1, ready_out;
  logic [5:0] data_out0, data_out1;
  logic       pop_D0, pop_D1, valid_out, dest_out, busy;
  logic [5:0] data_out;
  logic [7:0] count_D0, count_D1;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] q0[$], q1[$];        // physical FIFO contents seen by the DUT
  logic [5:0] m0[$], m1[$];        // model view of words not yet popped
  logic [5:0] exp_w[$];            // popped words awaiting delivery
  logic       exp_d[$];
  logic [5:0] acc_w[$];            // delivered words, in order
  logic       acc_d[$];
  logic       m_last;
  logic [7:0] m_cnt0, m_cnt1;
  int         lat, n_pops;
  bit         rand_ready, drop_on_pop;

  always #5 clk = ~clk;

  dest_drain_arbiter dut (
    .clk(clk), .reset(reset), .enable(enable),
    .empty_D0(empty_D0), .empty_D1(empty_D1),
    .data_out0(data_out0), .data_out1(data_out1), .ready_out(ready_out),
    .pop_D0(pop_D0), .pop_D1(pop_D1), .data_out(data_out),
    .valid_out(valid_out), .dest_out(dest_out),
    .count_D0(count_D0), .count_D1(count_D1), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic model_pick();
    if (m0.size() != 0 && m1.size() != 0) return ~m_last;
    else if (m0.size() != 0) return 1'b0;
    else return 1'b1;
  endfunction

  function automatic logic [7:0] exp_cnt(input logic d);
`ifdef DRAIN_COUNT_EN
    return d ? m_cnt1 : m_cnt0;
`else
    return 8'h00;
`endif
  endfunction

  task automatic push(input logic d, input logic [5:0] w);
    if (d) begin q1.push_back(w); m1.push_back(w); end
    else begin q0.push_back(w); m0.push_back(w); end
    empty_D0 = (q0.size() == 0);
    empty_D1 = (q1.size() == 0);
  endtask

  task automatic model_reset();
    exp_w.delete(); exp_d.delete();
    lat = 0; m_last = 1'b1; m_cnt0 = 8'h00; m_cnt1 = 8'h00;
  endtask

  // One clock: check at the falling edge, update FIFOs just after the rising edge
  task automatic step();
    logic d, p0, p1;
    @(negedge clk);
    p0 = pop_D0;
    p1 = pop_D1;
    if (lat == 2) begin
      check_eq("lat_n1_valid", valid_out, 1'b0);
      lat = 1;
    end else if (lat == 1) begin
      check_eq("lat_n2_valid", valid_out, 1'b1);
      if (exp_d.size() != 0) check_eq("lat_n2_dest", dest_out, exp_d[0]);
      lat = 0;
    end
    if (p0 || p1) begin
      d = p1;
      check_eq("pop_onehot", p0 & p1, 1'b0);
      check_eq("pop_choice", d, model_pick());
      check_eq("pop_nonempty", d ? (q1.size() != 0) : (q0.size() != 0), 1'b1);
      check_eq("pop_while_valid", valid_out, 1'b0);
      check_eq("busy_pop", busy, 1'b1);
      if (d && m1.size() != 0) exp_w.push_back(m1.pop_front());
      else if (!d && m0.size() != 0) exp_w.push_back(m0.pop_front());
      else exp_w.push_back(6'h00);
      exp_d.push_back(d);
      m_last = d;
      lat = 2;
      n_pops++;
      if (drop_on_pop) enable = 1'b0;
    end
    if (valid_out) begin
      if (exp_w.size() == 0) begin
        check_eq("spurious_valid", valid_out, 1'b0);
      end else begin
        check_eq("data_out", data_out, exp_w[0]);
        check_eq("dest_out", dest_out, exp_d[0]);
        check_eq("busy_hold", busy, 1'b1);
        if (ready_out) begin
          if (exp_d[0]) m_cnt1 = m_cnt1 + 8'd1;
          else m_cnt0 = m_cnt0 + 8'd1;
          check_eq(exp_d[0] ? "count_D1" : "count_D0",
                   exp_d[0] ? count_D1 : count_D0, exp_cnt(exp_d[0]));
          acc_w.push_back(data_out);
          acc_d.push_back(dest_out);
          void'(exp_w.pop_front());
          void'(exp_d.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    if (p0 && q0.size() != 0) data_out0 = q0.pop_front();
    if (p1 && q1.size() != 0) data_out1 = q1.pop_front();
    empty_D0 = (q0.size() == 0);
    empty_D1 = (q1.size() == 0);
    if (rand_ready) ready_out = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_pop(input int budget);
    int p = n_pops;
    int c = 0;
    while (n_pops == p && c < budget) begin step(); c++; end
    check_eq("pop_timeout", n_pops != p, 1'b1);
  endtask

  // Run until the model has nothing left (all) or nothing in flight (!all)
  task automatic drain(input int budget, input bit all);
    int c = 0;
    while (c < budget && ((all ? (m0.size() + m1.size()) : 0) + exp_w.size() + lat) != 0) begin
      step(); c++;
    end
    check_eq("drain_left", (all ? (m0.size() + m1.size()) : 0) + exp_w.size(), 0);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_count_D0", count_D0, exp_cnt(1'b0));
    check_eq("idle_count_D1", count_D1, exp_cnt(1'b1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int p;
    reset = 1'b1; enable = 1'b0; ready_out = 1'b0;
    data_out0 = 6'h00; data_out1 = 6'h00; empty_D0 = 1'b1; empty_D1 = 1'b1;
    n_pops = 0; rand_ready = 0; drop_on_pop = 0;
    model_reset();
    #1;
    check_eq("rst_pop", {pop_D1, pop_D0}, 2'b00);
    check_eq("rst_valid", valid_out, 1'b0);
    check_eq("rst_data", data_out, 6'h00);
    check_eq("rst_dest", dest_out, 1'b0);
    check_eq("rst_counts", {count_D1, count_D0}, 16'h0000);
    check_eq("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single word from D0
    push(1'b0, 6'h1B); enable = 1'b1; ready_out = 1'b1;
    drain(50, 1);
    check_eq("single_word", acc_w[acc_w.size()-1], 6'h1B);
    check_eq("single_pops", n_pops, 1);

    // Round-robin from a fresh reset
    do_reset();
    acc_w.delete(); acc_d.delete();
    push(1'b0, 6'h1C); push(1'b0, 6'h07); push(1'b1, 6'h2D); push(1'b1, 6'h33);
    drain(100, 1);
    check_eq("rr_order", {acc_w[0], acc_w[1], acc_w[2], acc_w[3]}, {6'h1C, 6'h2D, 6'h07, 6'h33});
    check_eq("rr_dest", {acc_d[0], acc_d[1], acc_d[2], acc_d[3]}, 4'b0101);

    // Backpressure: sink stalls for several cycles after capture
    push(1'b0, 6'h1A); push(1'b1, 6'h05);
    wait_pop(20);
    ready_out = 1'b0;
    p = n_pops;
    repeat (7) step();
    check_eq("bp_no_pop", n_pops, p);
    check_eq("bp_data", data_out, 6'h1A);
    check_eq("bp_valid", valid_out, 1'b1);
    ready_out = 1'b1;
    drain(50, 1);
    check_eq("bp_next_pop", n_pops, p + 1);

    // Enable drops while a pop is in flight
    acc_w.delete();
    push(1'b0, 6'h25); push(1'b0, 6'h11);
    enable = 1'b1; drop_on_pop = 1;
    wait_pop(20);
    drop_on_pop = 0;
    p = n_pops;
    drain(50, 0);
    repeat (5) step();
    check_eq("en_drop_word", acc_w[0], 6'h25);
    check_eq("en_drop_no_pop", n_pops, p);
    check_eq("en_drop_idle", busy, 1'b0);
    enable = 1'b1;
    drain(50, 1);

    // Reset while the word is being captured
    push(1'b0, 6'h3E); push(1'b1, 6'h0C);
    wait_pop(20);
    reset = 1'b1;
    #1;
    check_eq("midrst_valid", valid_out, 1'b0);
    check_eq("midrst_counts", {count_D1, count_D0}, 16'h0000);
    check_eq("midrst_busy", busy, 1'b0);
    model_reset();
    push(1'b0, 6'h21);
    @(posedge clk);
    #1 reset = 1'b0;
    acc_d.delete();
    drain(100, 1);
    check_eq("midrst_d0_first", acc_d[0], 1'b0);

    // 256 D1 drains wrap the counter
    do_reset();
    for (int i = 0; i < 256; i++) push(1'b1, 6'($urandom_range(0, 63)));
    drain(1000, 1);
    check_eq("wrap_count_D1", count_D1, 8'h00);
    check_eq("wrap_count_D0", count_D0, 8'h00);

    // Random mixes with random backpressure
    rand_ready = 1;
    for (int r = 0; r < 8; r++) begin
      int n0 = $urandom_range(0, 5);
      int n1 = $urandom_range(0, 5);
      for (int i = 0; i < n0; i++) push(1'b0, 6'($urandom_range(0, 63)));
      for (int i = 0; i < n1; i++) push(1'b1, 6'($urandom_range(0, 63)));
      drain(400, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
